// File: rtl/video_mode_ctrl.sv
// rtl/video_mode_ctrl.sv - front-panel mode/brightness controller
// Debounced key presses edit shadow registers that commit at vsync start.
module video_mode_ctrl #(
  parameter int DEBOUNCE_CYCLES  = 250000,
  parameter int NUM_MODES        = 8,
  parameter int LEVEL_RESET      = 4,
  parameter bit VSYNC_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] keys_n,
  input  logic       sw_override,
  input  logic [3:0] sw_func,
  input  logic       vsync,
  output logic [3:0] func,
  output logic [2:0] level,
  output logic       pending,
  output logic       commit
);

  localparam int            CW         = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX    = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0]    MODE_MAX   = 4'(NUM_MODES - 1);
  localparam logic [2:0]    LEVEL_INIT = 3'(LEVEL_RESET);
  localparam logic          VS_IDLE    = VSYNC_ACTIVE_LOW;

  logic [3:0]    r_sync1, r_sync2, r_db, r_db_d, r_press;
  logic [CW-1:0] r_cnt [4];
  logic [3:0]    r_mode_sh, r_mode_c, r_func;
  logic [2:0]    r_level_sh, r_level_c;
  logic          r_pending, r_commit, r_vs_prev, r_vs_start;
  logic [3:0]    w_mode_nxt;
  logic [2:0]    w_level_nxt;
  logic          w_vs_asserted, w_prev_asserted;

  // Per-key 2-FF synchronizer, debounce counter and press-edge detect
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
      r_db    <= '1;
      r_db_d  <= '1;
      r_press <= '0;
      for (int i = 0; i < 4; i++) r_cnt[i] <= '0;
    end else begin
      r_sync1 <= keys_n;
      r_sync2 <= r_sync1;
      r_db_d  <= r_db;
      r_press <= r_db_d & ~r_db;
      for (int i = 0; i < 4; i++) begin
        if (r_sync2[i] == r_db[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CNT_MAX) begin
          r_db[i]  <= ~r_db[i];
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CW'(1);
        end
      end
    end
  end

  // Opposing presses in the same cycle cancel; saturating level, wrapping mode
  always_comb begin
    w_mode_nxt  = r_mode_sh;
    w_level_nxt = r_level_sh;
    if (r_press[0] && !r_press[1])
      w_mode_nxt = (r_mode_sh == MODE_MAX) ? 4'd0 : r_mode_sh + 4'd1;
    else if (r_press[1] && !r_press[0])
      w_mode_nxt = (r_mode_sh == 4'd0) ? MODE_MAX : r_mode_sh - 4'd1;
    if (r_press[2] && !r_press[3])
      w_level_nxt = (r_level_sh == 3'd7) ? 3'd7 : r_level_sh + 3'd1;
    else if (r_press[3] && !r_press[2])
      w_level_nxt = (r_level_sh == 3'd0) ? 3'd0 : r_level_sh - 3'd1;
  end

  assign w_vs_asserted   = (vsync != VS_IDLE);
  assign w_prev_asserted = (r_vs_prev != VS_IDLE);

  // Commit samples the shadow before any same-cycle update lands
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_mode_sh  <= '0;
      r_mode_c   <= '0;
      r_level_sh <= LEVEL_INIT;
      r_level_c  <= LEVEL_INIT;
      r_pending  <= 1'b0;
      r_commit   <= 1'b0;
      r_vs_prev  <= VS_IDLE;
      r_vs_start <= 1'b0;
      r_func     <= '0;
    end else begin
      r_vs_prev  <= vsync;
      r_vs_start <= w_vs_asserted && !w_prev_asserted;
      r_mode_sh  <= w_mode_nxt;
      r_level_sh <= w_level_nxt;
      r_commit   <= r_vs_start && r_pending;
      if (r_vs_start && r_pending) begin
        r_mode_c  <= r_mode_sh;
        r_level_c <= r_level_sh;
      end
      r_pending <= (r_mode_sh != r_mode_c) || (r_level_sh != r_level_c);
      r_func    <= sw_override ? sw_func : r_mode_c;
    end
  end

  assign func    = r_func;
  assign level   = r_level_c;
  assign pending = r_pending;
  assign commit  = r_commit;

endmodule

// File: tb/tb_video_mode_ctrl.sv
// tb/tb_video_mode_ctrl.sv - self-checking bench for video_mode_ctrl
// Press-level model of shadow/committed state against the DUT outputs.
module tb_video_mode_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] keys_n = 4'hF;
  logic       sw_override = 1'b0;
  logic [3:0] sw_func = 4'h0;
  logic       vsync = 1'b1;
  logic [3:0] func;
  logic [2:0] level;
  logic       pending;
  logic       commit;

  int n_pass = 0;
  int n_total = 0;
  int n_commit = 0;

  int m_mode_sh, m_mode_c, m_level_sh, m_level_c;

  video_mode_ctrl #(
    .DEBOUNCE_CYCLES(4), .NUM_MODES(8), .LEVEL_RESET(4), .VSYNC_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .reset(reset), .keys_n(keys_n), .sw_override(sw_override),
    .sw_func(sw_func), .vsync(vsync), .func(func), .level(level),
    .pending(pending), .commit(commit)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (commit === 1'b1) n_commit++;
    end
  endtask

  function automatic void model_reset();
    m_mode_sh = 0; m_mode_c = 0; m_level_sh = 4; m_level_c = 4;
  endfunction

  function automatic void model_press(input logic [3:0] mask);
    if (mask[0] && !mask[1]) m_mode_sh = (m_mode_sh + 1) % 8;
    if (mask[1] && !mask[0]) m_mode_sh = (m_mode_sh + 7) % 8;
    if (mask[2] && !mask[3]) m_level_sh = (m_level_sh + 1 > 7) ? 7 : m_level_sh + 1;
    if (mask[3] && !mask[2]) m_level_sh = (m_level_sh - 1 < 0) ? 0 : m_level_sh - 1;
  endfunction

  function automatic int model_pending();
    return ((m_mode_sh != m_mode_c) || (m_level_sh != m_level_c)) ? 1 : 0;
  endfunction

  function automatic int model_vsync();
    if (model_pending() == 1) begin
      m_mode_c = m_mode_sh;
      m_level_c = m_level_sh;
      return 1;
    end
    return 0;
  endfunction

  task automatic press(input logic [3:0] mask);
    keys_n = ~mask;
    cyc(12);
    keys_n = 4'hF;
    cyc(12);
    model_press(mask);
  endtask

  task automatic frame();
    n_commit = 0;
    vsync = 1'b0;
    cyc(4);
    vsync = 1'b1;
    cyc(4);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    cyc(3);
    reset = 1'b1;
    cyc(1);
    model_reset();
    n_total++; if (func !== 4'd0) $display("FAIL reset_func: got %0h expected 0", func); else n_pass++;
    n_total++; if (level !== 3'd4) $display("FAIL reset_level: got %0d expected 4", level); else n_pass++;
    n_total++; if (pending !== 1'b0) $display("FAIL reset_pending: got %b expected 0", pending); else n_pass++;
    n_total++; if (commit !== 1'b0) $display("FAIL reset_commit: got %b expected 0", commit); else n_pass++;
  endtask

  task automatic test_press_commit();
    n_commit = 0;
    keys_n[0] = 1'b0;
    cyc(8);
    n_total++; if (pending !== 1'b0) $display("FAIL press_early: pending got %b expected 0", pending); else n_pass++;
    cyc(1);
    n_total++; if (pending !== 1'b1) $display("FAIL press_latency: pending got %b expected 1", pending); else n_pass++;
    cyc(11);
    keys_n = 4'hF;
    cyc(12);
    model_press(4'b0001);
    n_total++; if (func !== 4'd0 || n_commit != 0)
      $display("FAIL hold_no_commit: func %0h commits %0d expected func 0 commits 0", func, n_commit); else n_pass++;
    n_commit = 0;
    vsync = 1'b0;
    cyc(2);
    n_total++; if (commit !== 1'b1) $display("FAIL commit_timing: got %b expected 1", commit); else n_pass++;
    cyc(1);
    n_total++; if (func !== 4'd1) $display("FAIL commit_func: got %0h expected 1", func); else n_pass++;
    vsync = 1'b1;
    cyc(4);
    void'(model_vsync());
    n_total++; if (n_commit != 1 || pending !== 1'b0)
      $display("FAIL commit_once: commits %0d pending %b expected 1 and 0", n_commit, pending); else n_pass++;
  endtask

  task automatic test_wrap();
    int exp_c;
    press(4'b0010);
    press(4'b0010);
    frame();
    exp_c = model_vsync();
    n_total++; if (func !== 4'(m_mode_c) || n_commit != exp_c)
      $display("FAIL wrap_down: func %0h commits %0d expected %0h %0d", func, n_commit, m_mode_c, exp_c); else n_pass++;
    for (int i = 0; i < 8; i++) press(4'b0001);
    n_total++; if (pending !== 1'b0) $display("FAIL wrap_full_cycle: pending got %b expected 0", pending); else n_pass++;
    frame();
    exp_c = model_vsync();
    n_total++; if (func !== 4'd7 || n_commit != 0)
      $display("FAIL wrap_no_commit: func %0h commits %0d expected 7 0", func, n_commit); else n_pass++;
  endtask

  task automatic test_bounce();
    for (int i = 0; i < 10; i++) begin
      keys_n[2] = ~keys_n[2];
      cyc(2);
    end
    keys_n = 4'hF;
    cyc(12);
    n_total++; if (level !== 3'd4 || pending !== 1'b0)
      $display("FAIL bounce: level %0d pending %b expected 4 0", level, pending); else n_pass++;
  endtask

  task automatic test_level_sat();
    for (int i = 0; i < 5; i++) press(4'b0100);
    frame();
    void'(model_vsync());
    n_total++; if (level !== 3'd7) $display("FAIL level_sat_hi: got %0d expected 7", level); else n_pass++;
    press(4'b0100);
    n_total++; if (pending !== 1'b0) $display("FAIL sat_press_pending: got %b expected 0", pending); else n_pass++;
    for (int i = 0; i < 8; i++) press(4'b1000);
    frame();
    void'(model_vsync());
    n_total++; if (level !== 3'd0) $display("FAIL level_sat_lo: got %0d expected 0", level); else n_pass++;
  endtask

  task automatic test_simultaneous();
    press(4'b0011);
    n_total++; if (pending !== 1'b0) $display("FAIL mode_cancel: pending got %b expected 0", pending); else n_pass++;
    press(4'b0101);
    frame();
    void'(model_vsync());
    n_total++; if (func !== 4'(m_mode_c) || level !== 3'(m_level_c))
      $display("FAIL mode_and_level: func %0h level %0d expected %0h %0d", func, level, m_mode_c, m_level_c); else n_pass++;
  endtask

  task automatic test_conflict();
    int old_mode;
    press(4'b0100);
    old_mode = m_mode_c;
    keys_n[0] = 1'b0;
    cyc(6);
    n_commit = 0;
    vsync = 1'b0;
    cyc(4);
    keys_n = 4'hF;
    vsync = 1'b1;
    cyc(14);
    m_mode_c = m_mode_sh;
    m_level_c = m_level_sh;
    model_press(4'b0001);
    n_total++; if (n_commit != 1 || func !== 4'(old_mode) || level !== 3'(m_level_c))
      $display("FAIL conflict_first: commits %0d func %0h level %0d expected 1 %0h %0d",
               n_commit, func, level, old_mode, m_level_c); else n_pass++;
    n_total++; if (pending !== 1'b1) $display("FAIL conflict_pending: got %b expected 1", pending); else n_pass++;
    frame();
    void'(model_vsync());
    n_total++; if (n_commit != 1 || func !== 4'(m_mode_c))
      $display("FAIL conflict_second: commits %0d func %0h expected 1 %0h", n_commit, func, m_mode_c); else n_pass++;
  endtask

  task automatic test_override_reset();
    sw_func = 4'hA;
    sw_override = 1'b1;
    cyc(1);
    n_total++; if (func !== 4'hA) $display("FAIL override: got %0h expected a", func); else n_pass++;
    sw_override = 1'b0;
    cyc(1);
    n_total++; if (func !== 4'(m_mode_c)) $display("FAIL override_restore: got %0h expected %0h", func, m_mode_c); else n_pass++;
    press(4'b0001);
    n_total++; if (pending !== 1'b1) $display("FAIL pre_reset_pending: got %b expected 1", pending); else n_pass++;
    reset = 1'b0;
    cyc(2);
    reset = 1'b1;
    model_reset();
    cyc(1);
    n_total++; if (func !== 4'd0 || level !== 3'd4 || pending !== 1'b0)
      $display("FAIL mid_reset: func %0h level %0d pending %b expected 0 4 0", func, level, pending); else n_pass++;
    frame();
    n_total++; if (n_commit != 0) $display("FAIL reset_no_commit: commits %0d expected 0", n_commit); else n_pass++;
  endtask

  task automatic test_random();
    int op, exp_c;
    logic [3:0] mask;
    logic [3:0] exp_func;
    for (int it = 0; it < 30; it++) begin
      op = $urandom_range(0, 5);
      exp_c = 0;
      if (op <= 2) begin
        mask = 4'(1 << $urandom_range(0, 3));
        if ($urandom_range(0, 4) == 0) mask = mask | 4'(1 << $urandom_range(0, 3));
        press(mask);
      end else if (op <= 4) begin
        frame();
        exp_c = model_vsync();
        n_total++; if (n_commit != exp_c)
          $display("FAIL rand_commit_%0d: commits %0d expected %0d", it, n_commit, exp_c); else n_pass++;
      end else begin
        sw_override = 1'($urandom_range(0, 1));
        sw_func = 4'($urandom_range(0, 15));
        cyc(2);
      end
      exp_func = sw_override ? sw_func : 4'(m_mode_c);
      n_total++; if (func !== exp_func || level !== 3'(m_level_c) || pending !== 1'(model_pending()))
        $display("FAIL rand_state_%0d: func %0h level %0d pending %b expected %0h %0d %0d",
                 it, func, level, pending, exp_func, m_level_c, model_pending()); else n_pass++;
    end
    sw_override = 1'b0;
  endtask

  initial begin
    test_reset();
    test_press_commit();
    test_wrap();
    test_bounce();
    test_level_sat();
    test_simultaneous();
    test_conflict();
    test_override_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
